// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response collector: collector FSM states and default counter width.
package puf_pkg;

    localparam int PUF_CNT_W = 22;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DECIDE,
        SHIFT,
        DONE
    } puf_state_t;

endpackage

// File: rtl/puf_bit_decider.sv
// Turns the finish flags and counts of one oscillator pair into a single response bit.
module puf_bit_decider
    import puf_pkg::*;
#(
    parameter int CNT_W = PUF_CNT_W
) (
    input  logic             i_fin_a,
    input  logic             i_fin_b,
    input  logic [CNT_W-1:0] i_cnt_a,
    input  logic [CNT_W-1:0] i_cnt_b,
    output logic             o_bit
);

    // A tie on the finish flags falls back to the counts; equal counts resolve to 0.
    always_comb begin
        o_bit = 1'b0;
        if (i_fin_a && !i_fin_b) begin
            o_bit = 1'b1;
        end else if (i_fin_a && i_fin_b) begin
            o_bit = (i_cnt_a > i_cnt_b);
        end
    end

endmodule

// File: rtl/puf_response_collector.sv
// Ring-oscillator PUF response collector: races each oscillator pair and shifts one bit per pair.
// Optional RUN-state watchdog is enabled with macro PUF_TIMEOUT_EN.
module puf_response_collector
    import puf_pkg::*;
#(
    parameter int RESP_BITS      = 32,
    parameter int CNT_W          = PUF_CNT_W,
    parameter int TIMEOUT_CYCLES = 2**23
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cnt_a,
    input  logic [CNT_W-1:0]             cnt_b,
    input  logic                         fin_a,
    input  logic                         fin_b,
    input  logic                         resp_ack,
    output logic [$clog2(RESP_BITS)-1:0] ch_sel,
    output logic                         cnt_clr,
    output logic                         cnt_en,
    output logic [RESP_BITS-1:0]         resp_word,
    output logic                         resp_valid,
    output logic                         busy,
    output logic                         err
);

    localparam int                IDX_W    = $clog2(RESP_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RESP_BITS - 1);

    generate
        if (RESP_BITS < 2 || RESP_BITS > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("puf_response_collector: RESP_BITS must be 2..64 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    puf_state_t             r_state;
    logic [IDX_W-1:0]       r_bit_idx;
    logic                   r_bit;
    logic [RESP_BITS-1:0]   r_word;
    logic                   r_cnt_clr;
    logic                   r_cnt_en;
    logic                   r_valid;
    logic                   r_busy;

    logic                   w_fin_any;
    logic                   w_dec_bit;
    logic                   w_tmo_hit;
    logic                   w_tmo_flag;

    assign w_fin_any = fin_a | fin_b;

    puf_bit_decider #(
        .CNT_W (CNT_W)
    ) u_decider (
        .i_fin_a (fin_a),
        .i_fin_b (fin_b),
        .i_cnt_a (cnt_a),
        .i_cnt_b (cnt_b),
        .o_bit   (w_dec_bit)
    );

`ifdef PUF_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo;
    logic             r_err;

    // Fires on the last permitted RUN cycle when neither oscillator has finished.
    assign w_tmo_hit  = (r_state == RUN) && !w_fin_any && (r_tmo_cnt == TMO_LAST);
    assign w_tmo_flag = r_tmo;
    assign err        = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == CLEAR) begin
                r_tmo_cnt <= '0;
            end else if (r_state == RUN) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
                r_tmo     <= w_tmo_hit;
            end
            if (r_state == IDLE && start) begin
                r_err <= 1'b0;
            end else if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_hit  = 1'b0;
    assign w_tmo_flag = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_bit     <= 1'b0;
            r_word    <= '0;
            r_cnt_clr <= 1'b1;
            r_cnt_en  <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt_clr <= 1'b0;
                    if (start) begin
                        r_state   <= CLEAR;
                        r_bit_idx <= '0;
                        r_cnt_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state   <= RUN;
                    r_cnt_clr <= 1'b0;
                    r_cnt_en  <= 1'b1;
                end
                RUN: begin
                    if (w_fin_any || w_tmo_hit) begin
                        r_state  <= DECIDE;
                        r_cnt_en <= 1'b0;
                    end
                end
                DECIDE: begin
                    r_bit   <= w_dec_bit & ~w_tmo_flag;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_word <= {r_word[RESP_BITS-2:0], r_bit};
                    if (r_bit_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_state   <= CLEAR;
                        r_cnt_clr <= 1'b1;
                    end
                end
                DONE: begin
                    // An ack wins over a simultaneous start; the start is simply lost.
                    if (resp_ack) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt_clr <= 1'b0;
                    r_cnt_en  <= 1'b0;
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign ch_sel     = r_bit_idx;
    assign cnt_clr    = r_cnt_clr;
    assign cnt_en     = r_cnt_en;
    assign resp_word  = r_word;
    assign resp_valid = r_valid;
    assign busy       = r_busy;

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 Parameter RESP_BITS, default 32: response bits (challenge pairs) per run; legal 2..64.
REQ-002 Parameter CNT_W, default 22: oscillator counter width; the counter finishes on its MSB.
REQ-003 Parameter TIMEOUT_CYCLES, default 2^23: RUN-state cycle limit (used only with PUF_TIMEOUT_EN).
REQ-004 Ports, one per line, SHALL be:
 clk  in  1  single clock, rising edge.
 reset_n  in  1  asynchronous, active-low reset.
 start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
 cnt_a  in  CNT_W  count from oscillator-A counter.
 cnt_b  in  CNT_W  count from oscillator-B counter.
 fin_a  in  1  finished flag from counter A.
 fin_b  in  1  finished flag from counter B.
 resp_ack  in  1  consumer accepts resp_word.
 ch_sel  out  clog2(RESP_BITS)  oscillator-pair select to the upstream mux.
 cnt_clr  out  1  active-high reset to both counters.
 cnt_en  out  1  count enable to both counters.
 resp_word  out  RESP_BITS  collected response; first bit ends at the MSB.
 resp_valid  out  1  resp_word complete and stable.
 busy  out  1  high in every state except IDLE.
 err  out  1  sticky timeout flag.

Function
REQ-005 FSM states SHALL be IDLE, CLEAR, RUN, DECIDE, SHIFT, DONE.
REQ-006 IDLE->CLEAR on start; this transition clears bit_idx, ch_sel and err. resp_word holds its previous value until the first SHIFT.
REQ-007 CLEAR: cnt_clr=1 and cnt_en=0 for exactly one cycle, then RUN.
REQ-008 RUN: cnt_en=1 and cnt_clr=0; leave for DECIDE in the cycle after fin_a|fin_b is sampled high.
REQ-009 DECIDE: compute bit in one cycle:
 - fin_a&!fin_b -> bit=1.
 - !fin_a&fin_b -> bit=0.
 - both high -> bit = (cnt_a > cnt_b), unsigned compare; equal counts -> bit=0.
REQ-010 SHIFT: resp_word <= {resp_word[RESP_BITS-2:0], bit}.
 - bit_idx == RESP_BITS-1 -> DONE.
 - otherwise bit_idx and ch_sel increment, next state CLEAR.
REQ-011 ch_sel SHALL equal bit_idx and change only on the SHIFT edge; it is stable through CLEAR/RUN/DECIDE.
REQ-012 DONE: resp_valid=1 and resp_word frozen until resp_ack is sampled high, then IDLE (resp_valid low the next cycle).
REQ-013 start outside IDLE SHALL be ignored. start and resp_ack together in DONE: the ack is honoured and the start is dropped.
REQ-014 Per-bit latency SHALL be 1 (CLEAR) + N (RUN cycles up to and including the fin sample) + 1 (DECIDE) + 1 (SHIFT) cycles.
REQ-015 cnt_en and cnt_clr SHALL never both be high.

Reset
REQ-016 reset_n low SHALL asynchronously force IDLE, with resp_word=0, bit_idx=0, ch_sel=0, cnt_clr=1, cnt_en=0, resp_valid=0, busy=0, err=0.
REQ-017 Reset mid-run SHALL abandon the run; no partial resp_valid is produced. After release, cnt_clr=0 from the first clock edge.

Configuration
REQ-018 Macro PUF_TIMEOUT_EN defined: a RUN-cycle counter of width clog2(TIMEOUT_CYCLES+1) is added.
 - The counter clears on CLEAR entry.
 - If it reaches TIMEOUT_CYCLES without fin, go to DECIDE with bit=0 and set err.
 - err stays set until the next start.
REQ-019 Macro undefined: no timeout logic exists; RUN waits indefinitely; err is tied 0.

Structure
REQ-020 Shared package puf_pkg SHALL hold the FSM state enum typedef and the constant PUF_CNT_W=22.
REQ-021 One sub-module, puf_bit_decider, SHALL hold the REQ-009 decision logic. It is combinational and instantiated once.

Verification
REQ-022 The bench SHALL cover:
 - RESP_BITS=4; fin_a precedes fin_b on every pair -> resp_word=4'b1111, resp_valid after 4 runs, ch_sel sequence 0,1,2,3.
 - Pattern A,B,B,A first -> resp_word=4'b1001.
 - fin_a and fin_b in the same cycle: cnt_a=0x200001, cnt_b=0x200000 -> bit 1; equal counts -> bit 0.
 - reset_n low during RUN of bit 2 -> immediate IDLE with all outputs at reset values; a fresh start produces a correct full word.
 - With PUF_TIMEOUT_EN and TIMEOUT_CYCLES=16, fins held low -> DECIDE after 16 RUN cycles, bit 0, err=1; err clears on the next start.
 - start pulsed during RUN, and resp_ack withheld 10 cycles -> no restart; resp_valid and resp_word held stable for all 10 cycles.
